// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multi-port register file
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_REG_COUNT  = 32;

endpackage

// File: rtl/regfile_clr_fsm.sv
// rtl/regfile_clr_fsm.sv - background clear sequencer: sweeps one entry per cycle
// and blocks user writes while not idle
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int REG_COUNT  = RF_REG_COUNT
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  wr_ready,
    output logic                  sweep_we,
    output logic [ADDR_WIDTH-1:0] sweep_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

    clr_state_t            r_state;
    clr_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        clr_busy    = 1'b0;
        clr_done    = 1'b0;
        wr_ready    = 1'b0;
        sweep_we    = 1'b0;
        case (r_state)
            IDLE: begin
                wr_ready = 1'b1;
                if (clr_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_busy  = 1'b1;
                sweep_we  = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                clr_done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign sweep_addr = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised register file, one write port, RD_PORTS combinational reads
// Optional macro REGFILE_BYPASS_EN forwards a committing write to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int REG_COUNT  = RF_REG_COUNT,
    parameter int RD_PORTS   = 2,
    parameter int ZERO_REG0  = 0
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           wr_ready,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic                           clr_done
);

    localparam logic [ADDR_WIDTH:0] COUNT_W = (ADDR_WIDTH + 1)'(REG_COUNT);

    logic [DATA_WIDTH-1:0] r_mem [0:REG_COUNT-1];

    logic                  w_sweep_we;
    logic [ADDR_WIDTH-1:0] w_sweep_addr;
    logic                  w_wr_commit;

    regfile_clr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_clr_fsm (
        .clk        (clk),
        .nrst       (nrst),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .wr_ready   (wr_ready),
        .sweep_we   (w_sweep_we),
        .sweep_addr (w_sweep_addr)
    );

    // Dropped writes never reach the array nor the bypass path.
    assign w_wr_commit = wr_en && wr_ready && ({1'b0, wr_addr} < COUNT_W)
                         && !((ZERO_REG0 != 0) && (wr_addr == '0));

    // Sweep and user writes are exclusive: wr_ready is low whenever the sweep runs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_sweep_we) begin
            r_mem[w_sweep_addr] <= '0;
        end else if (w_wr_commit) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_data;

        assign w_addr = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_data = '0;
            if (({1'b0, w_addr} < COUNT_W) && !((ZERO_REG0 != 0) && (w_addr == '0))) begin
                w_data = r_mem[w_addr];
            end
`ifdef REGFILE_BYPASS_EN
            if (w_wr_commit && (w_addr == wr_addr)) begin
                w_data = wr_data;
            end
`endif
        end

        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = w_data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed checks of regfile_mp: default, ZERO_REG0=1 and REG_COUNT=20 builds
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        nrst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [4:0]  ra0, ra1;
    logic        clr_req;
    logic [9:0]  rd_addr;

    logic        m_rdy, m_busy, m_done;
    logic        z_rdy, z_busy, z_done;
    logic        s_rdy, s_busy, s_done;
    logic [31:0] m_rd, z_rd, s_rd;

    int n_checks = 0;
    int n_fail   = 0;

    assign rd_addr = {ra1, ra0};

    always #5 clk = ~clk;

    regfile_mp #(.REG_COUNT(32), .ZERO_REG0(0)) dut (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(m_rdy), .rd_addr(rd_addr), .rd_data(m_rd), .clr_req(clr_req),
        .clr_busy(m_busy), .clr_done(m_done));

    regfile_mp #(.REG_COUNT(32), .ZERO_REG0(1)) dut_z (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(z_rdy), .rd_addr(rd_addr), .rd_data(z_rd), .clr_req(clr_req),
        .clr_busy(z_busy), .clr_done(z_done));

    regfile_mp #(.REG_COUNT(20), .ZERO_REG0(0)) dut_s (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(s_rdy), .rd_addr(rd_addr), .rd_data(s_rd), .clr_req(clr_req),
        .clr_busy(s_busy), .clr_done(s_done));

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [15:0] m0, m1, z0, z1, s0, s1;
    } vec_t;

    vec_t vecs [9];

`ifdef REGFILE_BYPASS_EN
    localparam logic [15:0] BYP_SAME  = 16'h0BEE;
    localparam logic [15:0] BYP_OOB_M = 16'h2525;
`else
    localparam logic [15:0] BYP_SAME  = 16'h0333;
    localparam logic [15:0] BYP_OOB_M = 16'h0000;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int busy_cnt, done_cnt, done_at;

    initial begin
        nrst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        ra0 = 5'd5; ra1 = 5'd6; clr_req = 1'b0;

        vecs[0] = '{1'b0, 5'd0,  16'h0000, 5'd5,  5'd6,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 5'd5,  16'h1234, 5'd5,  5'd5,  16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
        vecs[2] = '{1'b0, 5'd0,  16'h0000, 5'd5,  5'd6,  16'h1234, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 16'h0000};
        vecs[3] = '{1'b1, 5'd0,  16'hFFFF, 5'd0,  5'd5,  16'hFFFF, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 16'h1234};
        vecs[4] = '{1'b1, 5'd31, 16'hBEEF, 5'd31, 5'd0,  16'hBEEF, 16'hFFFF, 16'hBEEF, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[5] = '{1'b0, 5'd7,  16'h5555, 5'd7,  5'd31, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
        vecs[6] = '{1'b1, 5'd5,  16'h0001, 5'd5,  5'd5,  16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        vecs[7] = '{1'b1, 5'd25, 16'hAAAA, 5'd25, 5'd19, 16'hAAAA, 16'h0000, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000};
        vecs[8] = '{1'b1, 5'd19, 16'h1919, 5'd19, 5'd25, 16'h1919, 16'hAAAA, 16'h1919, 16'hAAAA, 16'h1919, 16'h0000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("reset wr_ready", 16'(m_rdy), 16'h1);
        chk("reset clr_busy", 16'(m_busy), 16'h0);
        chk("reset clr_done", 16'(m_done), 16'h0);
        chk("reset rd_data0", m_rd[15:0], 16'h0);
        chk("reset rd_data1", m_rd[31:16], 16'h0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            ra0 = vecs[i].r0; ra1 = vecs[i].r1;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d main p0", i), m_rd[15:0],  vecs[i].m0);
            chk($sformatf("vec%0d main p1", i), m_rd[31:16], vecs[i].m1);
            chk($sformatf("vec%0d zero p0", i), z_rd[15:0],  vecs[i].z0);
            chk($sformatf("vec%0d zero p1", i), z_rd[31:16], vecs[i].z1);
            chk($sformatf("vec%0d rc20 p0", i), s_rd[15:0],  vecs[i].s0);
            chk($sformatf("vec%0d rc20 p1", i), s_rd[31:16], vecs[i].s1);
        end

        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 16'(a + 1);
        end
        @(negedge clk);
        wr_en = 1'b0;

        // Sweep: n counts edges after the one that samples clr_req.
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            clr_req = (n == 0 || n == 15);
            wr_en   = (n == 0 || n == 5);
            wr_addr = (n == 0) ? 5'd30 : 5'd25;
            wr_data = (n == 0) ? 16'h7777 : 16'h9999;
            ra0     = (n == 0) ? 5'd30 : 5'd9;
            ra1     = (n == 0) ? 5'd0 : ((n == 5) ? 5'd25 : 5'd20);
            @(posedge clk);
            #1;
            if (m_busy) busy_cnt++;
            if (m_done) begin
                done_cnt++;
                done_at = n;
            end
            if (n == 0) begin
                chk("sweep start write commits", m_rd[15:0], 16'h7777);
                chk("sweep start entry0 old", m_rd[31:16], 16'h0001);
                chk("sweep start wr_ready", 16'(m_rdy), 16'h0);
            end
            if (n == 5) begin
                chk("sweep wr_ready low", 16'(m_rdy), 16'h0);
                chk("sweep write dropped", m_rd[31:16], 16'd26);
            end
            if (n == 9) chk("sweep entry9 unswept", m_rd[15:0], 16'd10);
            if (n == 10) begin
                chk("sweep entry9 swept", m_rd[15:0], 16'h0);
                chk("sweep entry20 old", m_rd[31:16], 16'd21);
            end
            if (n == 33) begin
                chk("sweep wr_ready back", 16'(m_rdy), 16'h1);
                chk("sweep busy low", 16'(m_busy), 16'h0);
            end
        end
        chk("sweep busy cycles", 16'(busy_cnt), 16'd32);
        chk("sweep done pulses", 16'(done_cnt), 16'd1);
        chk("sweep done cycle", 16'(done_at), 16'd32);
        @(negedge clk);
        clr_req = 1'b0; wr_en = 1'b0; ra0 = 5'd30; ra1 = 5'd31;
        #1;
        chk("sweep entry30 cleared", m_rd[15:0], 16'h0);
        chk("sweep entry31 cleared", m_rd[31:16], 16'h0);

        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 16'h2020;
        @(negedge clk);
        wr_addr = 5'd31; wr_data = 16'h3131;
        for (int n = 0; n <= 8; n++) begin
            @(negedge clk);
            wr_en = 1'b0;
            clr_req = (n == 0);
        end
        @(negedge clk);
        clr_req = 1'b0;
        #1;
        chk("abort busy before reset", 16'(m_busy), 16'h1);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy", 16'(m_busy), 16'h0);
        chk("abort done", 16'(m_done), 16'h0);
        @(negedge clk);
        nrst = 1'b1; ra0 = 5'd20; ra1 = 5'd31;
        #1;
        chk("abort wr_ready", 16'(m_rdy), 16'h1);
        chk("abort entry20", m_rd[15:0], 16'h0);
        chk("abort entry31", m_rd[31:16], 16'h0);
        done_cnt = 0; busy_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (m_done) done_cnt++;
            if (m_busy) busy_cnt++;
        end
        chk("abort no done pulse", 16'(done_cnt), 16'h0);
        chk("abort no busy", 16'(busy_cnt), 16'h0);

        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 16'h0333;
        @(negedge clk);
        wr_data = 16'h0BEE; ra0 = 5'd4; ra1 = 5'd3;
        #1;
        chk("bypass same cycle", m_rd[31:16], BYP_SAME);
        @(posedge clk);
        #1;
        chk("bypass next cycle", m_rd[31:16], 16'h0BEE);
        @(negedge clk);
        wr_addr = 5'd25; wr_data = 16'h2525; ra0 = 5'd25;
        #1;
        chk("bypass rc20 out of range", s_rd[15:0], 16'h0);
        chk("bypass main addr25", m_rd[15:0], BYP_OOB_M);
        @(negedge clk);
        wr_addr = 5'd0; wr_data = 16'hF00F; ra0 = 5'd0;
        #1;
        chk("bypass zero reg0", z_rd[15:0], 16'h0);
        @(negedge clk);
        wr_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
